// File: rtl/tlb_cam_n_if.sv
// Lookup, write, Wired/Random and invalidate bundle for one TLB instance.
// The master side is the pipeline stage or control unit; the slave side is the TLB.
interface tlb_cam_n_if #(
  parameter int ENTRIES = 16,
  parameter int VPN_W   = 20,
  parameter int PTE_W   = 24,
  parameter int ASID_W  = 8
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [VPN_W-1:0]  lk_vpn;
  logic [ASID_W-1:0] lk_asid;
  logic              lk_hit;
  logic              lk_multi;
  logic [IDX_W-1:0]  lk_index;
  logic [PTE_W-1:0]  lk_pte;

  logic              wr_idx_en;
  logic              wr_rnd_en;
  logic [IDX_W-1:0]  wr_index;
  logic [VPN_W-1:0]  wr_vpn;
  logic [ASID_W-1:0] wr_asid;
  logic              wr_g;
  logic [PTE_W-1:0]  wr_pte;

  logic              wired_we;
  logic [IDX_W-1:0]  wired_in;
  logic [IDX_W-1:0]  wired;
  logic [IDX_W-1:0]  random;

  logic              inv_all;
  logic              inv_asid;
  logic [ASID_W-1:0] inv_asid_val;

  modport master (
    output lk_vpn, lk_asid,
    output wr_idx_en, wr_rnd_en, wr_index, wr_vpn, wr_asid, wr_g, wr_pte,
    output wired_we, wired_in,
    output inv_all, inv_asid, inv_asid_val,
    input  lk_hit, lk_multi, lk_index, lk_pte,
    input  wired, random
  );

  modport slave (
    input  lk_vpn, lk_asid,
    input  wr_idx_en, wr_rnd_en, wr_index, wr_vpn, wr_asid, wr_g, wr_pte,
    input  wired_we, wired_in,
    input  inv_all, inv_asid, inv_asid_val,
    output lk_hit, lk_multi, lk_index, lk_pte,
    output wired, random
  );
endinterface

// File: rtl/tlb_cam_n.sv
// Fully-associative TLB with ASID/global tagging, Wired-bounded random
// replacement, bulk and per-ASID invalidation, and multi-hit detection.
// Lookup is combinational and always reflects pre-edge contents.
module tlb_cam_n #(
  parameter int ENTRIES = 16,
  parameter int VPN_W   = 20,
  parameter int PTE_W   = 24,
  parameter int ASID_W  = 8
) (
  input  logic         clock,
  input  logic         resetn,
  tlb_cam_n_if.slave   bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);
  localparam logic [ENTRIES-1:0] ONE = {{(ENTRIES-1){1'b0}}, 1'b1};

  // Entry payload is not reset; only the valid bits carry meaning after reset.
  logic [VPN_W-1:0]   vpn_q  [ENTRIES];
  logic [ASID_W-1:0]  asid_q [ENTRIES];
  logic [PTE_W-1:0]   pte_q  [ENTRIES];
  logic [ENTRIES-1:0] glob_q;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] match;
  logic [IDX_W-1:0]   hit_idx;
  logic [IDX_W-1:0]   wired_q, wired_d;
  logic [IDX_W-1:0]   random_q, random_d;
  logic [IDX_W-1:0]   wr_tgt;
  logic               wr_en;

  // Per-entry tag compare; a global entry ignores the ASID.
  always_comb begin
    match = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match[i] = valid_q[i] && (vpn_q[i] == bus.lk_vpn) &&
                 (glob_q[i] || (asid_q[i] == bus.lk_asid));
    end
  end

  // Priority encode: scanning downward leaves the lowest matching index.
  always_comb begin
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = IDX_W'(i);
    end
  end

  // Clearing the lowest set bit leaves something only when two or more matched.
  assign bus.lk_hit   = |match;
  assign bus.lk_multi = |(match & (match - ONE));
  assign bus.lk_index = hit_idx;
  assign bus.lk_pte   = bus.lk_hit ? pte_q[hit_idx] : '0;

  assign bus.wired  = wired_q;
  assign bus.random = random_q;

  // Indexed write takes precedence; a random write uses the pre-edge victim.
  assign wr_en  = bus.wr_idx_en | bus.wr_rnd_en;
  assign wr_tgt = bus.wr_idx_en ? bus.wr_index : random_q;

  // Random walks down to Wired then wraps to the top; loading Wired restarts it.
  always_comb begin
    wired_d  = wired_q;
    random_d = random_q;
    if (bus.wired_we) begin
      wired_d  = bus.wired_in;
      random_d = LAST;
    end else if (random_q <= wired_q) begin
      random_d = LAST;
    end else begin
      random_d = random_q - 1'b1;
    end
  end

  // Invalidate first, then the write, so a written entry always ends valid.
  always_comb begin
    valid_d = valid_q;
    if (bus.inv_all) begin
      valid_d = '0;
    end else if (bus.inv_asid) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (!glob_q[i] && (asid_q[i] == bus.inv_asid_val)) valid_d[i] = 1'b0;
      end
    end
    if (wr_en) valid_d[wr_tgt] = 1'b1;
  end

  // Control state: valid bits, Wired and Random.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid_q  <= '0;
      wired_q  <= '0;
      random_q <= LAST;
    end else begin
      valid_q  <= valid_d;
      wired_q  <= wired_d;
      random_q <= random_d;
    end
  end

  // Entry payload storage.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      vpn_q[wr_tgt]  <= bus.wr_vpn;
      asid_q[wr_tgt] <= bus.wr_asid;
      glob_q[wr_tgt] <= bus.wr_g;
      pte_q[wr_tgt]  <= bus.wr_pte;
    end
  end
endmodule

// File: tb/tb_tlb_cam_n.sv
// Self-checking bench for tlb_cam_n: directed scenarios followed by random
// traffic, all checked against an array-based reference model.
module tb_tlb_cam_n;
  localparam int ENTRIES = 16;
  localparam int VPN_W   = 20;
  localparam int PTE_W   = 24;
  localparam int ASID_W  = 8;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  tlb_cam_n_if #(.ENTRIES(ENTRIES), .VPN_W(VPN_W), .PTE_W(PTE_W), .ASID_W(ASID_W)) bus ();

  tlb_cam_n #(.ENTRIES(ENTRIES), .VPN_W(VPN_W), .PTE_W(PTE_W), .ASID_W(ASID_W)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  bit                m_valid [ENTRIES];
  bit                m_g     [ENTRIES];
  logic [VPN_W-1:0]  m_vpn   [ENTRIES];
  logic [ASID_W-1:0] m_asid  [ENTRIES];
  logic [PTE_W-1:0]  m_pte   [ENTRIES];
  int                m_wired;
  int                m_random;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_wired  = 0;
    m_random = ENTRIES - 1;
  endtask

  task automatic model_lookup(input logic [VPN_W-1:0] vpn, input logic [ASID_W-1:0] asid,
                              output bit hit, output bit multi, output int idx,
                              output logic [PTE_W-1:0] pte);
    int cnt = 0;
    idx = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (m_valid[i] && m_vpn[i] == vpn && (m_g[i] || m_asid[i] == asid)) begin
        if (cnt == 0) idx = i;
        cnt++;
      end
    end
    hit   = (cnt > 0);
    multi = (cnt > 1);
    pte   = hit ? m_pte[idx] : '0;
  endtask

  task automatic check_all();
    bit hit, multi;
    int idx;
    logic [PTE_W-1:0] pte;
    model_lookup(bus.lk_vpn, bus.lk_asid, hit, multi, idx, pte);
    check("lk_hit",   32'(bus.lk_hit),   32'(hit));
    check("lk_multi", 32'(bus.lk_multi), 32'(multi));
    check("lk_index", 32'(bus.lk_index), idx);
    check("lk_pte",   32'(bus.lk_pte),   32'(pte));
    check("wired",    32'(bus.wired),    m_wired);
    check("random",   32'(bus.random),   m_random);
  endtask

  // Apply the rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    int old_r = m_random;
    int tgt;
    if (bus.wired_we) begin
      m_wired  = int'(bus.wired_in);
      m_random = ENTRIES - 1;
    end else begin
      m_random = (old_r <= m_wired) ? ENTRIES - 1 : old_r - 1;
    end
    if (bus.inv_all) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    end else if (bus.inv_asid) begin
      for (int i = 0; i < ENTRIES; i++)
        if (!m_g[i] && m_asid[i] == bus.inv_asid_val) m_valid[i] = 1'b0;
    end
    if (bus.wr_idx_en || bus.wr_rnd_en) begin
      tgt = bus.wr_idx_en ? int'(bus.wr_index) : old_r;
      m_valid[tgt] = 1'b1;
      m_vpn[tgt]   = bus.wr_vpn;
      m_asid[tgt]  = bus.wr_asid;
      m_g[tgt]     = bus.wr_g;
      m_pte[tgt]   = bus.wr_pte;
    end
  endtask

  task automatic idle_inputs();
    bus.wr_idx_en    = 1'b0;
    bus.wr_rnd_en    = 1'b0;
    bus.wired_we     = 1'b0;
    bus.inv_all      = 1'b0;
    bus.inv_asid     = 1'b0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    #1 check_all();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic set_wr(input int idx, input logic [VPN_W-1:0] vpn, input logic [ASID_W-1:0] asid,
                        input bit g, input logic [PTE_W-1:0] pte);
    bus.wr_index = 4'(idx);
    bus.wr_vpn   = vpn;
    bus.wr_asid  = asid;
    bus.wr_g     = g;
    bus.wr_pte   = pte;
  endtask

  task automatic wr_idx(input int idx, input logic [VPN_W-1:0] vpn, input logic [ASID_W-1:0] asid,
                        input bit g, input logic [PTE_W-1:0] pte);
    set_wr(idx, vpn, asid, g, pte);
    bus.wr_idx_en = 1'b1;
    tick();
  endtask

  task automatic look(input logic [VPN_W-1:0] vpn, input logic [ASID_W-1:0] asid);
    bus.lk_vpn  = vpn;
    bus.lk_asid = asid;
    #1;
  endtask

  initial begin
    idle_inputs();
    set_wr(0, '0, '0, 1'b0, '0);
    bus.wired_in     = '0;
    bus.inv_asid_val = '0;
    bus.lk_vpn       = '0;
    bus.lk_asid      = '0;
    model_reset();
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    // T1: reset state
    look(20'h12345, 8'd0);
    check("t1_random", 32'(bus.random), 15);
    check("t1_wired",  32'(bus.wired), 0);
    check("t1_hit",    32'(bus.lk_hit), 0);
    check("t1_pte",    32'(bus.lk_pte), 0);
    tick();

    // T2: indexed write, ASID match, global bit
    wr_idx(5, 20'h80001, 8'd3, 1'b0, 24'hA00042);
    look(20'h80001, 8'd3);
    check("t2_hit", 32'(bus.lk_hit), 1);
    check("t2_idx", 32'(bus.lk_index), 5);
    check("t2_pte", 32'(bus.lk_pte), 32'h00A00042);
    tick();
    look(20'h80001, 8'd4);
    check("t2_asid_miss", 32'(bus.lk_hit), 0);
    tick();
    wr_idx(5, 20'h80001, 8'd3, 1'b1, 24'hA00042);
    look(20'h80001, 8'd4);
    check("t2_global_hit", 32'(bus.lk_hit), 1);
    tick();

    // T3: Wired=3, random sequence and a random write at random==3
    bus.wired_we = 1'b1;
    bus.wired_in = 4'd3;
    tick();
    for (int e = 15; e >= 3; e--) begin
      if (e == 3) begin
        set_wr(0, 20'h33333, 8'd1, 1'b0, 24'h000123);
        bus.wr_rnd_en = 1'b1;
      end
      #1 check("t3_seq", 32'(bus.random), e);
      tick();
    end
    look(20'h33333, 8'd1);
    check("t3_wrap", 32'(bus.random), 15);
    check("t3_rnd_idx", 32'(bus.lk_index), 3);
    check("t3_rnd_hit", 32'(bus.lk_hit), 1);
    tick();
    #1 check("t3_after_wrap", 32'(bus.random), 14);

    // T4: duplicate entries resolve to lowest index
    wr_idx(2, 20'h44444, 8'd5, 1'b0, 24'h000111);
    wr_idx(9, 20'h44444, 8'd5, 1'b0, 24'h000999);
    look(20'h44444, 8'd5);
    check("t4_hit",   32'(bus.lk_hit), 1);
    check("t4_multi", 32'(bus.lk_multi), 1);
    check("t4_idx",   32'(bus.lk_index), 2);
    check("t4_pte",   32'(bus.lk_pte), 32'h111);
    tick();

    // T5: per-ASID invalidate, then inv_all together with a write
    wr_idx(10, 20'h55555, 8'd7, 1'b0, 24'h00AAAA);
    wr_idx(11, 20'h55556, 8'd7, 1'b1, 24'h00BBBB);
    wr_idx(12, 20'h55557, 8'd8, 1'b0, 24'h00CCCC);
    bus.inv_asid     = 1'b1;
    bus.inv_asid_val = 8'd7;
    tick();
    look(20'h55555, 8'd7);
    check("t5_asid7_gone", 32'(bus.lk_hit), 0);
    tick();
    look(20'h55556, 8'd7);
    check("t5_global_kept", 32'(bus.lk_hit), 1);
    tick();
    look(20'h55557, 8'd8);
    check("t5_asid8_kept", 32'(bus.lk_hit), 1);
    tick();
    bus.inv_all = 1'b1;
    set_wr(0, 20'h66666, 8'd2, 1'b0, 24'h000666);
    bus.wr_idx_en = 1'b1;
    tick();
    look(20'h66666, 8'd2);
    check("t5_wr_survives", 32'(bus.lk_hit), 1);
    check("t5_wr_idx", 32'(bus.lk_index), 0);
    tick();
    look(20'h55556, 8'd7);
    check("t5_all_cleared", 32'(bus.lk_hit), 0);
    tick();

    // T6: simultaneous indexed and random write at random==12
    for (int k = 0; k < 40 && m_random != 12; k++) tick();
    check("t6_reach12", 32'(bus.random), 12);
    set_wr(4, 20'h77777, 8'd2, 1'b0, 24'h000777);
    bus.wr_idx_en = 1'b1;
    bus.wr_rnd_en = 1'b1;
    tick();
    look(20'h77777, 8'd2);
    check("t6_idx",   32'(bus.lk_index), 4);
    check("t6_multi", 32'(bus.lk_multi), 0);
    check("t6_hit",   32'(bus.lk_hit), 1);
    tick();

    // Reset mid-cycle takes effect without a clock edge
    #3 resetn = 1'b0;
    model_reset();
    #1;
    check("rst_hit",    32'(bus.lk_hit), 0);
    check("rst_random", 32'(bus.random), 15);
    check("rst_wired",  32'(bus.wired), 0);
    check("rst_pte",    32'(bus.lk_pte), 0);
    @(negedge clock);
    resetn = 1'b1;

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      set_wr($urandom_range(0, ENTRIES - 1), 20'h01000 + 20'($urandom_range(0, 3)),
             8'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0), 24'($urandom));
      bus.wr_idx_en    = ($urandom_range(0, 3) == 0);
      bus.wr_rnd_en    = ($urandom_range(0, 3) == 0);
      bus.wired_we     = ($urandom_range(0, 29) == 0);
      bus.wired_in     = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 8));
      bus.inv_all      = ($urandom_range(0, 39) == 0);
      bus.inv_asid     = ($urandom_range(0, 14) == 0);
      bus.inv_asid_val = 8'($urandom_range(0, 2));
      bus.lk_vpn       = 20'h01000 + 20'($urandom_range(0, 3));
      bus.lk_asid      = 8'($urandom_range(0, 2));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
